// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle functional-unit sequencing with a timeout that parks in ERR.
module pipe_hazard_ctrl #(
  parameter int unsigned FU_TIMEOUT = 32
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [2:0]  ID_rs_i,
  input  logic [2:0]  ID_rt_i,
  input  logic        ID_useRs_i,
  input  logic        ID_useRt_i,
  input  logic        IDEX_memRead_i,
  input  logic [2:0]  IDEX_rd_i,
  input  logic        IDEX_multiCycle_i,
  input  logic        fu_done_i,
  input  logic        branch_taken_i,
  output logic        pc_en_o,
  output logic        IFID_en_o,
  output logic        IDEX_en_o,
  output logic        IFID_flush_o,
  output logic        IDEX_flush_o,
  output logic        EXMEM_bubble_o,
  output logic        fu_start_o,
  output logic        err_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StFuWait = 2'b01,
    StErr    = 2'b11
  } state_e;

  // Last wait-counter value before the FU is declared hung.
  localparam logic [7:0] WaitLast = 8'(FU_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;

  // Register 0 is compared like any other address.
  assign load_use = IDEX_memRead_i &
                    ((ID_useRs_i & (ID_rs_i == IDEX_rd_i)) |
                     (ID_useRt_i & (ID_rt_i == IDEX_rd_i)));

  // Next-state and pipeline-control decode; reset overrides to a frozen pipe.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    pc_en_o        = 1'b1;
    IFID_en_o      = 1'b1;
    IDEX_en_o      = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_flush_o   = 1'b0;
    EXMEM_bubble_o = 1'b0;
    fu_start_o     = 1'b0;

    case (state_q)
      StRun: begin
        if (IDEX_multiCycle_i) begin
          fu_start_o     = 1'b1;
          pc_en_o        = 1'b0;
          IFID_en_o      = 1'b0;
          IDEX_en_o      = 1'b0;
          EXMEM_bubble_o = 1'b1;
          state_d        = StFuWait;
          wait_cnt_d     = 8'd0;
        end else if (branch_taken_i) begin
          IFID_flush_o = 1'b1;
          IDEX_flush_o = 1'b1;
        end else if (load_use) begin
          pc_en_o      = 1'b0;
          IFID_en_o    = 1'b0;
          IDEX_flush_o = 1'b1;
        end
      end
      StFuWait: begin
        if (fu_done_i) begin
          state_d = StRun;
        end else begin
          pc_en_o        = 1'b0;
          IFID_en_o      = 1'b0;
          IDEX_en_o      = 1'b0;
          EXMEM_bubble_o = 1'b1;
          if (wait_cnt_q == WaitLast) begin
            state_d = StErr;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        pc_en_o        = 1'b0;
        IFID_en_o      = 1'b0;
        IDEX_en_o      = 1'b0;
        EXMEM_bubble_o = 1'b1;
      end
    endcase

    if (!rst_n) begin
      pc_en_o        = 1'b0;
      IFID_en_o      = 1'b0;
      IDEX_en_o      = 1'b0;
      IFID_flush_o   = 1'b0;
      IDEX_flush_o   = 1'b0;
      EXMEM_bubble_o = 1'b1;
      fu_start_o     = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State, wait counter and stall counter registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign err_o       = (state_q == StErr);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default timeout and timeout 4)
// share stimulus and are checked against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO0 = 32;
  localparam int unsigned TO1 = 4;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       use_rs, use_rt, mem_read, multi, fu_done, br_taken;

  logic [1:0] pc_en, ifid_en, idex_en, ifid_fl, idex_fl, bub, start, err;
  logic [1:0] st[2];
  logic [15:0] stall[2];

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: 0 = running, 1 = waiting on FU, 3 = error.
  int m_st[2], m_wt[2], m_stall[2];
  logic [1:0] e_pc, e_ifid, e_idex, e_ifl, e_idfl, e_bub, e_start;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.FU_TIMEOUT(TO0)) dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .ID_rs_i(id_rs), .ID_rt_i(id_rt),
    .ID_useRs_i(use_rs), .ID_useRt_i(use_rt), .IDEX_memRead_i(mem_read),
    .IDEX_rd_i(ex_rd), .IDEX_multiCycle_i(multi), .fu_done_i(fu_done),
    .branch_taken_i(br_taken), .pc_en_o(pc_en[0]), .IFID_en_o(ifid_en[0]),
    .IDEX_en_o(idex_en[0]), .IFID_flush_o(ifid_fl[0]), .IDEX_flush_o(idex_fl[0]),
    .EXMEM_bubble_o(bub[0]), .fu_start_o(start[0]), .err_o(err[0]),
    .state_o(st[0]), .stall_cnt_o(stall[0])
  );

  pipe_hazard_ctrl #(.FU_TIMEOUT(TO1)) dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .ID_rs_i(id_rs), .ID_rt_i(id_rt),
    .ID_useRs_i(use_rs), .ID_useRt_i(use_rt), .IDEX_memRead_i(mem_read),
    .IDEX_rd_i(ex_rd), .IDEX_multiCycle_i(multi), .fu_done_i(fu_done),
    .branch_taken_i(br_taken), .pc_en_o(pc_en[1]), .IFID_en_o(ifid_en[1]),
    .IDEX_en_o(idex_en[1]), .IFID_flush_o(ifid_fl[1]), .IDEX_flush_o(idex_fl[1]),
    .EXMEM_bubble_o(bub[1]), .fu_start_o(start[1]), .err_o(err[1]),
    .state_o(st[1]), .stall_cnt_o(stall[1])
  );

  function automatic int unsigned timeout_of(int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  function automatic logic [25:0] obs(int k);
    return {pc_en[k], ifid_en[k], idex_en[k], ifid_fl[k], idex_fl[k], bub[k], start[k],
            err[k], st[k], stall[k]};
  endfunction

  function automatic logic [25:0] expv(int k);
    return {e_pc[k], e_ifid[k], e_idex[k], e_ifl[k], e_idfl[k], e_bub[k], e_start[k],
            (m_st[k] == 3), 2'(m_st[k]), 16'(m_stall[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_wt[k] = 0; m_stall[k] = 0;
    end
  endtask

  // Expected control outputs from the current model state and inputs.
  task automatic model_eval();
    logic lu;
    lu = mem_read && ((use_rs && id_rs == ex_rd) || (use_rt && id_rt == ex_rd));
    for (int k = 0; k < 2; k++) begin
      logic frozen;
      frozen = !rst_n || m_st[k] == 3 || (m_st[k] == 1 && !fu_done) ||
               (m_st[k] == 0 && multi);
      e_start[k] = rst_n && m_st[k] == 0 && multi;
      e_ifl[k]   = rst_n && m_st[k] == 0 && !multi && br_taken;
      e_idfl[k]  = rst_n && m_st[k] == 0 && !multi && (br_taken || lu);
      e_bub[k]   = frozen;
      e_idex[k]  = !frozen;
      e_pc[k]    = !frozen && !(rst_n && m_st[k] == 0 && !multi && !br_taken && lu);
      e_ifid[k]  = e_pc[k];
    end
  endtask

  // Advance the model by one rising edge.
  task automatic model_clock();
    model_eval();
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (!e_pc[k] && m_stall[k] < 65535) m_stall[k]++;
        if (m_st[k] == 0 && multi) begin
          m_st[k] = 1; m_wt[k] = 0;
        end else if (m_st[k] == 1) begin
          if (fu_done) m_st[k] = 0;
          else if (m_wt[k] == int'(timeout_of(k)) - 1) m_st[k] = 3;
          else m_wt[k]++;
        end
      end
    end
  endtask

  task automatic idle();
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0; use_rs = 1'b0; use_rt = 1'b0;
    mem_read = 1'b0; multi = 1'b0; fu_done = 1'b0; br_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic apply_reset();
    idle();
    @(negedge clk_i);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_n = 1'b0;
    model_reset();
    multi = 1'b1; br_taken = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({st[k], err[k], stall[k], pc_en[k], ifid_en[k], idex_en[k], ifid_fl[k], idex_fl[k],
           bub[k], start[k]} !== {2'b00, 1'b0, 16'h0, 7'b0000010}) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got st=%b err=%b stall=%0h ctl=%b%b%b%b%b%b%b",
                 k, st[k], err[k], stall[k], pc_en[k], ifid_en[k], idex_en[k], ifid_fl[k],
                 idex_fl[k], bub[k], start[k]);
      end
    end
    apply_reset();
  endtask

  task automatic test_load_use();
    apply_reset();
    mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; use_rs = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({pc_en[k], ifid_en[k], idex_en[k], idex_fl[k], ifid_fl[k]} !== 5'b00110) begin
        miscompares++;
        $display("FAIL load_use dut%0d: got %b want 00110", k,
                 {pc_en[k], ifid_en[k], idex_en[k], idex_fl[k], ifid_fl[k]});
      end
    end
    tick();
    idle();
    settle();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({stall[k], pc_en[k]} !== {16'd1, 1'b1}) begin
        miscompares++;
        $display("FAIL load_use_count dut%0d: got stall=%0d pc_en=%b want 1,1", k, stall[k],
                 pc_en[k]);
      end
    end
  endtask

  task automatic test_no_false_load_use();
    apply_reset();
    for (int v = 0; v < 3; v++) begin
      mem_read = (v != 1); ex_rd = 3'd3; id_rs = 3'd3; use_rs = (v != 0);
      id_rt = 3'd0; use_rt = (v == 2);
      settle();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({pc_en[k], ifid_en[k], idex_fl[k]} !== (v == 2 ? 3'b001 : 3'b110)) begin
          miscompares++;
          $display("FAIL no_false_load_use v%0d dut%0d: got %b", v, k,
                   {pc_en[k], ifid_en[k], idex_fl[k]});
        end
      end
      tick();
      if (v == 1) begin
        idle();
        settle();
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (stall[k] !== 16'd0) begin
            miscompares++;
            $display("FAIL no_false_count dut%0d: got %0d want 0", k, stall[k]);
          end
        end
      end
    end
  endtask

  task automatic test_fu_op();
    int starts;
    int waits;
    starts = 0; waits = 0;
    apply_reset();
    multi = 1'b1;
    settle();
    starts += start[0];
    vectors++;
    if ({start[0], pc_en[0], ifid_en[0], idex_en[0], bub[0], st[0]} !== 7'b1000100) begin
      miscompares++;
      $display("FAIL fu_entry: got %b want 1000100",
               {start[0], pc_en[0], ifid_en[0], idex_en[0], bub[0], st[0]});
    end
    tick();
    multi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fu_done = (i == 4);
      settle();
      starts += start[0];
      if (st[0] == 2'b01) waits++;
      vectors++;
      if ({pc_en[0], ifid_en[0], idex_en[0], bub[0]} !== (i == 4 ? 4'b1110 : 4'b0001)) begin
        miscompares++;
        $display("FAIL fu_wait cycle%0d: got %b", i,
                 {pc_en[0], ifid_en[0], idex_en[0], bub[0]});
      end
      vectors++;
      if (obs(1) !== expv(1)) begin
        miscompares++;
        $display("FAIL fu_wait_t4 cycle%0d: got %h want %h", i, obs(1), expv(1));
      end
      tick();
    end
    fu_done = 1'b0;
    settle();
    vectors++;
    if ({starts, waits, 2'(st[0]), stall[0]} !== {32'd1, 32'd5, 2'b00, 16'd5}) begin
      miscompares++;
      $display("FAIL fu_op_summary: got starts=%0d waits=%0d st=%b stall=%0d want 1 5 00 5",
               starts, waits, st[0], stall[0]);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    multi = 1'b1;
    tick();
    multi = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 3; i++) begin
      fu_done = (i == 1);
      settle();
      vectors++;
      if ({st[1], err[1], pc_en[1], bub[1]} !== 5'b11101) begin
        miscompares++;
        $display("FAIL timeout_err cycle%0d: got %b want 11101", i,
                 {st[1], err[1], pc_en[1], bub[1]});
      end
      vectors++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("FAIL timeout_t32 cycle%0d: got %h want %h", i, obs(0), expv(0));
      end
      tick();
    end
    apply_reset();
    multi = 1'b1;
    tick();
    multi = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    fu_done = 1'b1;
    settle();
    vectors++;
    if ({st[1], pc_en[1], bub[1]} !== 4'b0110) begin
      miscompares++;
      $display("FAIL timeout_done_wins: got %b want 0110", {st[1], pc_en[1], bub[1]});
    end
    tick();
    fu_done = 1'b0;
    settle();
    vectors++;
    if ({st[1], err[1], stall[1]} !== {2'b00, 1'b0, 16'd4}) begin
      miscompares++;
      $display("FAIL timeout_back_to_run: got st=%b err=%b stall=%0d want 00 0 4", st[1],
               err[1], stall[1]);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    multi = 1'b1; br_taken = 1'b1; mem_read = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; use_rt = 1'b1;
    settle();
    vectors++;
    if ({start[0], ifid_fl[0], idex_fl[0], pc_en[0]} !== 4'b1000) begin
      miscompares++;
      $display("FAIL prio_multi: got %b want 1000",
               {start[0], ifid_fl[0], idex_fl[0], pc_en[0]});
    end
    tick();
    idle();
    settle();
    vectors++;
    if (st[0] !== 2'b01) begin
      miscompares++;
      $display("FAIL prio_multi_state: got %b want 01", st[0]);
    end
    apply_reset();
    br_taken = 1'b1; mem_read = 1'b1; ex_rd = 3'd0; id_rs = 3'd0; use_rs = 1'b1;
    settle();
    vectors++;
    if ({ifid_fl[0], idex_fl[0], pc_en[0], ifid_en[0], idex_en[0]} !== 5'b11111) begin
      miscompares++;
      $display("FAIL prio_branch: got %b want 11111",
               {ifid_fl[0], idex_fl[0], pc_en[0], ifid_en[0], idex_en[0]});
    end
    tick();
    idle();
    settle();
    vectors++;
    if ({st[0], stall[0]} !== 18'd0) begin
      miscompares++;
      $display("FAIL prio_branch_after: got st=%b stall=%0d want 00 0", st[0], stall[0]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    multi = 1'b1;
    tick();
    multi = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    // dut0 is mid-wait, dut1 has timed out: reset both between edges.
    @(negedge clk_i);
    vectors++;
    if ({st[0], st[1], err[1]} !== 5'b01111) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got %b want 01111", {st[0], st[1], err[1]});
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({st[k], err[k], stall[k], start[k], pc_en[k], bub[k]} !== {2'b00, 1'b0, 16'd0,
                                                                     3'b001}) begin
        miscompares++;
        $display("FAIL reset_mid_async dut%0d: got st=%b err=%b stall=%0d ctl=%b", k, st[k],
                 err[k], stall[k], {start[k], pc_en[k], bub[k]});
      end
    end
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({st[k], start[k], pc_en[k], stall[k]} !== {2'b00, 1'b0, 1'b1, 16'd0}) begin
        miscompares++;
        $display("FAIL reset_mid_release dut%0d: got st=%b start=%b pc_en=%b stall=%0d", k,
                 st[k], start[k], pc_en[k], stall[k]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      if (!rst_n) model_reset();
      multi    = ($urandom_range(0, 7) == 0);
      fu_done  = ($urandom_range(0, 2) == 0);
      br_taken = ($urandom_range(0, 3) == 0);
      mem_read = $urandom_range(0, 1);
      use_rs   = $urandom_range(0, 1);
      use_rt   = $urandom_range(0, 1);
      id_rs    = 3'($urandom_range(0, 7));
      id_rt    = 3'($urandom_range(0, 7));
      ex_rd    = 3'($urandom_range(0, 7));
      settle();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL random i%0d dut%0d: got %h want %h", i, k, obs(k), expv(k));
        end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    apply_reset();
    multi = 1'b1;
    tick();
    multi = 1'b0;
    for (int i = 0; i < 65540; i++) tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({stall[k], err[k]} !== {16'hFFFF, 1'b1} || obs(k) !== expv(k)) begin
        miscompares++;
        $display("FAIL saturation dut%0d: got stall=%h err=%b want FFFF 1", k, stall[k],
                 err[k]);
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_load_use();
    test_no_false_load_use();
    test_fu_op();
    test_timeout();
    test_priority();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
